// File: rtl/fp_accum_seq_pkg.sv
// Shared constants, state encoding and accumulator-update helper for fp_accum_seq.
package fp_accum_seq_pkg;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Overflow poisons the running value with a quiet NaN; underflow flushes it to zero.
    function automatic logic [31:0] acc_merge(input logic [31:0] sum,
                                              input logic        ovf,
                                              input logic        unf);
        logic [31:0] r;
        r = sum;
        if (ovf)
            r = FP_QNAN;
        else if (unf)
            r = FP_ZERO;
        return r;
    endfunction

endpackage

// File: rtl/fp_accum_seq.sv
// Purpose: sequences a binary32 operand stream through an external adder and returns one sum per job.
// Latency: one operand per cycle; out_valid rises the cycle after the last accepted operand (after start if len==0).
// Backpressure: in_ready only in LOAD/ACC; result held in DONE until out_ready, new starts ignored meanwhile.
module fp_accum_seq
    import fp_accum_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             sub_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_sel,
    input  logic [31:0]      add_s,
    input  logic             add_ovf,
    input  logic             add_unf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic             out_unf,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    state_t           state;
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] len_q;
    logic             sub_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             in_fire;
    logic [CNT_W-1:0] cnt_inc;

    assign in_fire = in_valid & in_ready_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // The adder sees the running value and the live operand in every state.
    assign add_a   = acc_q;
    assign add_b   = in_data;
    assign add_sel = sub_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc_q       <= FP_ZERO;
            len_q       <= '0;
            sub_q       <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        sub_q  <= sub_mode;
                        acc_q  <= FP_ZERO;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // First operand seeds the accumulator without touching the adder.
                    if (in_fire) begin
                        acc_q <= in_data;
                        cnt_q <= CNT_W'(1);
                        if (len_q == CNT_W'(1)) begin
                            state       <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_fire) begin
                        acc_q <= acc_merge(add_s, add_ovf, add_unf);
                        cnt_q <= cnt_inc;
                        ovf_q <= ovf_q | add_ovf;
                        unf_q <= unf_q | add_unf;
                        if (add_ovf || (cnt_inc == len_q)) begin
                            state       <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq with a behavioural binary32 adder on the add_* ports.
module tb_fp_accum_seq;

    localparam int CNT_W = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             sub_mode;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_sel;
    logic [31:0]      add_s;
    logic             add_ovf;
    logic             add_unf;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_ovf;
    logic             out_unf;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] ops [0:7];

    fp_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .sub_mode(sub_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_sel(add_sel),
        .add_s(add_s), .add_ovf(add_ovf), .add_unf(add_unf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_count(out_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)
            return 0.0;
        if (f[30:23] == 8'hFF)
            d = {f[31], 11'h7FF, f[22:0], 29'h0};
        else
            d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    // Stand-in adder: exact in double, rounded to binary32; underflow returns a nonzero denormal.
    function automatic logic [33:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic sel);
        real         r;
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        logic [31:0] s;
        logic        o;
        logic        u;
        r = sel ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        d = $realtobits(r);
        o = 1'b0;
        u = 1'b0;
        e = int'(d[62:52]);
        if (e == 0) begin
            s = 32'h0;
        end else if (e == 2047) begin
            o = 1'b1;
            s = {d[63], 8'hFF, 23'h0};
        end else begin
            m = {1'b0, d[51:29]} + {23'h0, d[28]};
            e = e - 1023 + 127;
            if (m[23]) e = e + 1;
            if (e >= 255) begin
                o = 1'b1;
                s = {d[63], 8'hFF, 23'h0};
            end else if (e <= 0) begin
                u = 1'b1;
                s = {d[63], 8'h00, 1'b1, m[22:1]};
            end else begin
                s = {d[63], e[7:0], m[22:0]};
            end
        end
        return {s, o, u};
    endfunction

    assign {add_s, add_ovf, add_unf} = fp_add(add_a, add_b, add_sel);

    // Job-level reference: fold the operand list with the adder, stop on overflow.
    task automatic model(input int ln, input bit sb, output logic [31:0] d, output int c,
                         output bit o, output bit u);
        logic [33:0] r;
        d = 32'h0; c = 0; o = 1'b0; u = 1'b0;
        for (int i = 0; i < ln; i++) begin
            if (i == 0) begin
                d = ops[0];
            end else begin
                r = fp_add(d, ops[i], sb);
                o = o | r[1];
                u = u | r[0];
                if (r[1]) d = QNAN;
                else if (r[0]) d = 32'h0;
                else d = r[33:2];
            end
            c = i + 1;
            if (o) break;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string tag, input int ln, input bit sb, input int n,
                           input bit rnd, input int hold, input logic [31:0] e_d,
                           input int e_c, input bit e_o, input bit e_u);
        int idx;
        int cyc;
        bit vld;
        bit fire;
        bit last_fire;
        bit seen_rdy;
        start = 1'b1; len = CNT_W'(ln); sub_mode = sb; in_valid = 1'b0; out_ready = 1'b0;
        step();
        start = 1'b0;
        idx = 0; cyc = 0; last_fire = 1'b0; seen_rdy = 1'b0;
        while (!out_valid && cyc < 100) begin
            vld = (idx < n) && (!rnd || $urandom_range(0, 2) != 0);
            in_valid = vld;
            in_data = (vld && idx < 8) ? ops[idx] : 32'($urandom);
            fire = vld && in_ready;
            if (in_ready) seen_rdy = 1'b1;
            step();
            if (fire) idx++;
            last_fire = fire;
            cyc++;
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        if (ln > 0) chk({tag, " latency"}, 32'(last_fire), 32'd1);
        else chk({tag, " in_ready_seen"}, 32'(seen_rdy), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data = 32'($urandom);
            start = 1'($urandom);
            len = CNT_W'($urandom_range(0, 5));
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " hold_data"}, out_data, e_d);
            step();
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_count"}, 32'(out_count), 32'(e_c));
        end
        start = 1'b0; in_valid = 1'b0;
        chk({tag, " data"}, out_data, e_d);
        chk({tag, " count"}, 32'(out_count), 32'(e_c));
        chk({tag, " ovf"}, 32'(out_ovf), 32'(e_o));
        chk({tag, " unf"}, 32'(out_unf), 32'(e_u));
        chk({tag, " accepted"}, 32'(idx), 32'(e_c));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          ln;
        bit          sb;
        logic [31:0] op0, op1, op2, op3;
        logic [31:0] e_d;
        int          e_c;
        bit          e_o;
        bit          e_u;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] md;
        int          mc;
        bit          mo;
        bit          mu;
        int          ln;
        bit          sb;

        vecs[0] = '{3, 0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 3, 0, 0};
        vecs[1] = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000, 0, 0, 0};
        vecs[2] = '{2, 1, 32'h40A00000, 32'h40000000, 32'h0, 32'h0, 32'h40400000, 2, 0, 0};
        vecs[3] = '{4, 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 2, 1, 0};
        vecs[4] = '{3, 1, 32'h00C00000, 32'h00800000, 32'h3F800000, 32'h0, 32'hBF800000, 3, 0, 1};
        vecs[5] = '{1, 1, 32'hC0490FDB, 32'h0, 32'h0, 32'h0, 32'hC0490FDB, 1, 0, 0};
        vecs[6] = '{2, 0, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h00000000, 2, 0, 0};

        rst = 1'b1; start = 1'b0; len = '0; sub_mode = 1'b0; in_valid = 1'b0;
        in_data = 32'h0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst add_sel", 32'(add_sel), 32'd0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_count", 32'(out_count), 32'd0);

        for (int i = 0; i < 7; i++) begin
            ops[0] = vecs[i].op0; ops[1] = vecs[i].op1;
            ops[2] = vecs[i].op2; ops[3] = vecs[i].op3;
            run_job($sformatf("vec%0d", i), vecs[i].ln, vecs[i].sb,
                    (vecs[i].ln > 4) ? 4 : vecs[i].ln, 1'b0, i % 3,
                    vecs[i].e_d, vecs[i].e_c, vecs[i].e_o, vecs[i].e_u);
        end

        // Gapped input with a long output stall and start pulses during DONE.
        ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000;
        run_job("stall", 3, 1'b0, 3, 1'b1, 5, 32'h40C00000, 3, 1'b0, 1'b0);

        // Reset while accumulating drops the job.
        start = 1'b1; len = 8'd3; sub_mode = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h40A00000;
        step();
        chk("mid count", 32'(out_count), 32'd1);
        chk("mid busy", 32'(busy), 32'd1);
        in_data = 32'h3F800000; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst in_ready", 32'(in_ready), 32'd0);
        chk("mrst out_valid", 32'(out_valid), 32'd0);
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst add_sel", 32'(add_sel), 32'd0);
        chk("mrst out_data", out_data, 32'h0);
        chk("mrst out_count", 32'(out_count), 32'd0);
        chk("mrst flags", {30'h0, out_ovf, out_unf}, 32'h0);

        for (int j = 0; j < 25; j++) begin
            ln = $urandom_range(0, 6);
            sb = 1'($urandom);
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 9) == 0)
                    ops[k] = {1'b0, 8'hFE, 23'($urandom)};
                else
                    ops[k] = {1'($urandom), 8'($urandom_range(124, 130)), 23'($urandom)};
            end
            model(ln, sb, md, mc, mo, mu);
            run_job($sformatf("rnd%0d", j), ln, sb, ln, 1'b1, $urandom_range(0, 5), md, mc, mo, mu);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
